// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch control block: state codes,
// adjust field selects and the button slot order used by the debouncers.
package stopwatch_pkg;

    // State codes driven on the state output
    localparam logic [1:0] ST_PAUSED  = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_ADJUST  = 2'd2;

    // Field selects carried on sel_sw / adj_sel
    localparam logic [1:0] SEL_FIELD0 = 2'd0;
    localparam logic [1:0] SEL_FIELD1 = 2'd1;
    localparam logic [1:0] SEL_FIELD2 = 2'd2;
    localparam logic [1:0] SEL_FIELD3 = 2'd3;

    // Slot of each push button in the debouncer bank
    localparam int NUM_BTNS  = 4;
    localparam int BTN_PAUSE = 0;
    localparam int BTN_RST   = 1;
    localparam int BTN_INC   = 2;
    localparam int BTN_DEC   = 3;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stable-count debouncer
// and a one-cycle press pulse on the rising edge of the debounced level.
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_meta_reg;
    logic             sync_reg;
    logic [CNT_W-1:0] stable_cnt_reg;
    logic             level_reg;
    logic             level_d_reg;
    logic             press_reg;

    // Bring the raw button into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_reg <= 1'b0;
            sync_reg      <= 1'b0;
        end else begin
            sync_meta_reg <= raw;
            sync_reg      <= sync_meta_reg;
        end
    end

    // Accept a new level only after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_cnt_reg <= '0;
            level_reg      <= 1'b0;
        end else if (sync_reg == level_reg) begin
            stable_cnt_reg <= '0;
        end else if (stable_cnt_reg == CNT_LAST) begin
            stable_cnt_reg <= '0;
            level_reg      <= sync_reg;
        end else begin
            stable_cnt_reg <= stable_cnt_reg + 1'b1;
        end
    end

    // Registered rising-edge detect; releases never produce a pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d_reg <= 1'b0;
            press_reg   <= 1'b0;
        end else begin
            level_d_reg <= level_reg;
            press_reg   <= level_reg & ~level_d_reg;
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: conditions buttons and switches, sequences
// run/pause/adjust and issues single-cycle strobes to the BCD datapath.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 1000,
    parameter int DB_CYCLES = 16,
    parameter int BLINK_DIV = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_btn,
    input  logic       rst_btn,
    input  logic       inc_btn,
    input  logic       dec_btn,
    input  logic       down_sw,
    input  logic       adj_sw,
    input  logic [1:0] sel_sw,
    input  logic       at_zero,
    output logic       count_en,
    output logic       count_dn,
    output logic       clear,
    output logic       adj_inc,
    output logic       adj_dec,
    output logic [1:0] adj_sel,
    output logic       blink,
    output logic [1:0] state
);

    localparam int TICK_W  = $clog2(TICK_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_press;

    assign btn_raw[BTN_PAUSE] = pause_btn;
    assign btn_raw[BTN_RST]   = rst_btn;
    assign btn_raw[BTN_INC]   = inc_btn;
    assign btn_raw[BTN_DEC]   = dec_btn;

    // btn_level is kept for visibility; only the press pulses drive the FSM
    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_db
            btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
                .clk   (clk),
                .rst   (rst),
                .raw   (btn_raw[gi]),
                .level (btn_level[gi]),
                .press (btn_press[gi])
            );
        end
    endgenerate

    logic pause_press, rst_press, inc_press, dec_press;
    assign pause_press = btn_press[BTN_PAUSE];
    assign rst_press   = btn_press[BTN_RST];
    assign inc_press   = btn_press[BTN_INC];
    assign dec_press   = btn_press[BTN_DEC];

    // Switch bundle {sel_sw, adj_sw, down_sw}; levels only, no debounce
    logic [3:0] sw_meta_reg, sw_sync_reg;

    // Two-flop synchronizer for the slide switches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
        end else begin
            sw_meta_reg <= {sel_sw, adj_sw, down_sw};
            sw_sync_reg <= sw_meta_reg;
        end
    end

    logic adj_req;
    assign adj_req  = sw_sync_reg[1];
    assign count_dn = sw_sync_reg[0];
    assign adj_sel  = sw_sync_reg[3:2];

    logic [1:0]         state_reg, state_next;
    logic [TICK_W-1:0]  tick_reg, tick_next;
    logic [BLINK_W-1:0] blink_div_reg, blink_div_next;
    logic               blink_reg, blink_next;
    logic               count_en_reg, count_en_next;
    logic               clear_reg, clear_next;
    logic               adj_inc_reg, adj_inc_next;
    logic               adj_dec_reg, adj_dec_next;

    // Next-state and strobe decode; priority rst press > adj_sw > pause > tick
    always_comb begin
        state_next     = state_reg;
        tick_next      = tick_reg;
        count_en_next  = 1'b0;
        clear_next     = 1'b0;
        blink_div_next = '0;
        blink_next     = 1'b0;

        if (rst_press) begin
            clear_next = 1'b1;
            tick_next  = '0;
            if (state_reg != ST_ADJUST) state_next = ST_PAUSED;
        end else if (adj_req) begin
            state_next = ST_ADJUST;
        end else begin
            case (state_reg)
                ST_PAUSED: begin
                    if (pause_press) begin
                        state_next = ST_RUNNING;
                        tick_next  = '0;
                    end
                end
                ST_RUNNING: begin
                    if (pause_press) begin
                        state_next = ST_PAUSED;
                    end else if (count_dn && at_zero) begin
                        // Never step a down-counter below zero
                        state_next = ST_PAUSED;
                    end else if (tick_reg == TICK_LAST) begin
                        tick_next     = '0;
                        count_en_next = 1'b1;
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
                // Leaving ADJUST, or recovering from the unused code 3
                default: state_next = ST_PAUSED;
            endcase
        end

        // Blink runs only while staying in ADJUST; entry restarts it from 0
        if (state_next == ST_ADJUST && state_reg == ST_ADJUST) begin
            if (blink_div_reg == BLINK_LAST) begin
                blink_div_next = '0;
                blink_next     = ~blink_reg;
            end else begin
                blink_div_next = blink_div_reg + 1'b1;
                blink_next     = blink_reg;
            end
        end

        adj_inc_next = (state_reg == ST_ADJUST) && inc_press && !dec_press;
        adj_dec_next = (state_reg == ST_ADJUST) && dec_press && !inc_press;
    end

    // State, dividers and registered strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_PAUSED;
            tick_reg      <= '0;
            blink_div_reg <= '0;
            blink_reg     <= 1'b0;
            count_en_reg  <= 1'b0;
            clear_reg     <= 1'b0;
            adj_inc_reg   <= 1'b0;
            adj_dec_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tick_reg      <= tick_next;
            blink_div_reg <= blink_div_next;
            blink_reg     <= blink_next;
            count_en_reg  <= count_en_next;
            clear_reg     <= clear_next;
            adj_inc_reg   <= adj_inc_next;
            adj_dec_reg   <= adj_dec_next;
        end
    end

    assign state    = state_reg;
    assign count_en = count_en_reg;
    assign clear    = clear_reg;
    assign adj_inc  = adj_inc_reg;
    assign adj_dec  = adj_dec_reg;
    assign blink    = blink_reg;

endmodule
